// File: rtl/conv_filter_stream.sv
// Streaming strided, zero-padded 2-D convolution: buffers one square input map,
// then computes each output with a single time-multiplexed signed MAC.
module conv_filter_stream #(
    parameter int DATA_W      = 32,
    parameter int INPUT_SIZE  = 7,
    parameter int FILTER_SIZE = 3,
    parameter int STRIDE      = 2,
    parameter int PAD         = 0,
    parameter int RELU        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_valid,
    output logic              coef_ready,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int OUT_SIZE = (INPUT_SIZE + 2*PAD - FILTER_SIZE) / STRIDE + 1;
    localparam int NPIX     = INPUT_SIZE * INPUT_SIZE;
    localparam int NTAP     = FILTER_SIZE * FILTER_SIZE;
    localparam int ACC_W    = 2*DATA_W + $clog2(NTAP + 1);
    localparam int PCW      = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CCW      = $clog2(NTAP + 1);
    localparam int TW       = $clog2(FILTER_SIZE + 1);
    localparam int OW       = $clog2(OUT_SIZE + 1);
    localparam int IW       = 32;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

    logic        [DATA_W-1:0] r_buf  [NPIX];
    logic signed [DATA_W-1:0] r_taps [NTAP];
    logic signed [DATA_W-1:0] r_bias;
    state_t                   r_state;
    logic [PCW-1:0]           r_pix_cnt;
    logic [CCW-1:0]           r_coef_cnt;
    logic [OW-1:0]            r_orow, r_ocol;
    logic [TW-1:0]            r_tr, r_tc;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_coef_ready, r_in_ready, r_out_valid, r_out_last, r_busy;
    logic [DATA_W-1:0]        r_out_data;

    logic                     w_pix_fire, w_coef_fire, w_inb, w_last_pos;
    logic [IW-1:0]            w_rp, w_cp;
    logic [PCW-1:0]           w_idx;
    logic [CCW-1:0]           w_tap_idx;
    logic signed [DATA_W-1:0] w_pix;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_nxt, w_bias_ext;
    logic [DATA_W-1:0]        w_res;

    assign w_pix_fire  = (r_state == S_LOAD) && in_valid && r_in_ready;
    assign w_coef_fire = (r_state == S_LOAD) && coef_valid && r_coef_ready;

    // Padded coordinates are kept offset by PAD so the bounds test stays unsigned.
    assign w_rp  = IW'(r_orow) * IW'(STRIDE) + IW'(r_tr);
    assign w_cp  = IW'(r_ocol) * IW'(STRIDE) + IW'(r_tc);
    assign w_inb = (w_rp >= IW'(PAD)) && (w_rp < IW'(INPUT_SIZE + PAD)) &&
                   (w_cp >= IW'(PAD)) && (w_cp < IW'(INPUT_SIZE + PAD));
    assign w_idx = PCW'(w_rp - IW'(PAD)) * PCW'(INPUT_SIZE) + PCW'(w_cp - IW'(PAD));
    assign w_tap_idx = CCW'(r_tr) * CCW'(FILTER_SIZE) + CCW'(r_tc);

    assign w_pix      = w_inb ? r_buf[w_idx] : {DATA_W{1'b0}};
    assign w_prod     = w_pix * r_taps[w_tap_idx];
    assign w_acc_nxt  = r_acc + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};
    assign w_last_pos = (r_orow == OW'(OUT_SIZE - 1)) && (r_ocol == OW'(OUT_SIZE - 1));

    // Saturate the final accumulation to the output range, with optional ReLU clamp.
    always_comb begin
        w_res = {DATA_W{1'b0}};
        if ((RELU != 0) && w_acc_nxt[ACC_W-1]) begin
            w_res = {DATA_W{1'b0}};
        end else if (w_acc_nxt > ACC_MAX) begin
            w_res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_acc_nxt < ACC_MIN) begin
            w_res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            w_res = w_acc_nxt[DATA_W-1:0];
        end
    end

    // Pixel buffer and coefficient storage; deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_pix_fire) begin
                r_buf[r_pix_cnt] <= in_data;
            end
            if (w_coef_fire) begin
                if (r_coef_cnt < CCW'(NTAP)) begin
                    r_taps[r_coef_cnt] <= coef_data;
                end else begin
                    r_bias <= coef_data;
                end
            end
        end
    end

    // Control FSM, MAC accumulator and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_LOAD;
            r_pix_cnt    <= {PCW{1'b0}};
            r_coef_cnt   <= {CCW{1'b0}};
            r_orow       <= {OW{1'b0}};
            r_ocol       <= {OW{1'b0}};
            r_tr         <= {TW{1'b0}};
            r_tc         <= {TW{1'b0}};
            r_acc        <= {ACC_W{1'b0}};
            r_coef_ready <= 1'b1;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= {DATA_W{1'b0}};
            r_busy       <= 1'b0;
        end else begin
            if (w_coef_fire) begin
                r_coef_cnt <= (r_coef_cnt == CCW'(NTAP)) ? {CCW{1'b0}} : r_coef_cnt + CCW'(1);
            end
            case (r_state)
                S_LOAD: begin
                    if (w_pix_fire) begin
                        r_coef_ready <= 1'b0;
                        if (r_pix_cnt == PCW'(NPIX - 1)) begin
                            r_pix_cnt  <= {PCW{1'b0}};
                            r_state    <= S_MAC;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_acc      <= w_bias_ext;
                            r_orow     <= {OW{1'b0}};
                            r_ocol     <= {OW{1'b0}};
                            r_tr       <= {TW{1'b0}};
                            r_tc       <= {TW{1'b0}};
                        end else begin
                            r_pix_cnt <= r_pix_cnt + PCW'(1);
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    if (r_tc == TW'(FILTER_SIZE - 1)) begin
                        r_tc <= {TW{1'b0}};
                        if (r_tr == TW'(FILTER_SIZE - 1)) begin
                            r_tr        <= {TW{1'b0}};
                            r_state     <= S_OUT;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                            r_out_last  <= w_last_pos;
                        end else begin
                            r_tr <= r_tr + TW'(1);
                        end
                    end else begin
                        r_tc <= r_tc + TW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_last_pos) begin
                            r_state      <= S_LOAD;
                            r_in_ready   <= 1'b1;
                            r_coef_ready <= 1'b1;
                            r_busy       <= 1'b0;
                            r_orow       <= {OW{1'b0}};
                            r_ocol       <= {OW{1'b0}};
                        end else begin
                            r_state <= S_MAC;
                            r_acc   <= w_bias_ext;
                            if (r_ocol == OW'(OUT_SIZE - 1)) begin
                                r_ocol <= {OW{1'b0}};
                                r_orow <= r_orow + OW'(1);
                            end else begin
                                r_ocol <= r_ocol + OW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign coef_ready = r_coef_ready;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign busy       = r_busy;

endmodule

// File: tb/tb_conv_filter_stream.sv
// Directed bench: three instances (defaults, PAD=1, RELU=1) share stimulus buses;
// sel routes valid strobes to one instance at a time.
module tb_conv_filter_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        g_cv, g_iv, out_ready;
    logic [31:0] coef_data, in_data;
    int          sel;
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_q[$];

    logic        cv[3], iv[3], cr[3], ir[3], ov[3], ol[3], bz[3];
    logic [31:0] od[3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_sel
        assign cv[k] = g_cv && (sel == k);
        assign iv[k] = g_iv && (sel == k);
    end

    conv_filter_stream u_def (
        .clk(clk), .reset(reset), .coef_valid(cv[0]), .coef_ready(cr[0]), .coef_data(coef_data),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]), .busy(bz[0]));

    conv_filter_stream #(.PAD(1)) u_pad (
        .clk(clk), .reset(reset), .coef_valid(cv[1]), .coef_ready(cr[1]), .coef_data(coef_data),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]), .busy(bz[1]));

    conv_filter_stream #(.RELU(1)) u_relu (
        .clk(clk), .reset(reset), .coef_valid(cv[2]), .coef_ready(cr[2]), .coef_data(coef_data),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Offer one word on the coef or pixel bus; starts and ends just after a negedge.
    task automatic push_word(input bit is_coef, input logic [31:0] d);
        int   t;
        logic rdy;
        if (is_coef) begin coef_data = d; g_cv = 1'b1; end
        else begin in_data = d; g_iv = 1'b1; end
        t   = 0;
        rdy = is_coef ? cr[sel] : ir[sel];
        while (!rdy && t < 100) begin
            @(negedge clk);
            t++;
            rdy = is_coef ? cr[sel] : ir[sel];
        end
        chk(is_coef ? "coef_accept" : "pix_accept", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        g_cv = 1'b0;
        g_iv = 1'b0;
    endtask

    // mode 0: all-ones taps, mode 1: centre tap only.
    task automatic load_coef(input int mode, input logic [31:0] bias);
        for (int i = 0; i < 9; i++) begin
            push_word(1'b1, (mode == 0 || i == 4) ? 32'd1 : 32'd0);
        end
        push_word(1'b1, bias);
    endtask

    // mode 0: constant v, mode 1: ascending 0..48.
    task automatic send_frame(input int mode, input logic [31:0] v);
        for (int p = 0; p < 49; p++) begin
            push_word(1'b0, (mode == 1) ? 32'(p) : v);
        end
    endtask

    task automatic fill_exp(input int n, input logic [31:0] v);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic collect(input int n, input int stall);
        int          t;
        logic [31:0] held;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!ov[sel] && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("out_valid", {31'd0, ov[sel]}, 32'd1);
            if (stall > 0) begin
                out_ready = 1'b0;
                held = od[sel];
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    chk("stall_hold", od[sel], held);
                    chk("stall_valid", {31'd0, ov[sel]}, 32'd1);
                end
            end
            chk("in_ready_hold", {31'd0, ir[sel]}, 32'd0);
            chk("out_data", od[sel], exp_q[i]);
            chk("out_last", {31'd0, ol[sel]}, (i == n - 1) ? 32'd1 : 32'd0);
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("post_hs_valid", {31'd0, ov[sel]}, 32'd0);
        end
        chk("in_ready_after", {31'd0, ir[sel]}, 32'd1);
    endtask

    initial begin
        int lat;
        reset = 1'b1; g_cv = 1'b0; g_iv = 1'b0; out_ready = 1'b1;
        coef_data = 32'd0; in_data = 32'd0; sel = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_coef_ready", {31'd0, cr[k]}, 32'd1);
            chk("rst_in_ready",   {31'd0, ir[k]}, 32'd1);
            chk("rst_out_valid",  {31'd0, ov[k]}, 32'd0);
            chk("rst_out_last",   {31'd0, ol[k]}, 32'd0);
            chk("rst_out_data",   od[k], 32'd0);
            chk("rst_busy",       {31'd0, bz[k]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // All-ones map and filter: 9 outputs of 9, latency counted from the final-pixel cycle.
        sel = 0;
        load_coef(0, 32'd0);
        send_frame(0, 32'd1);
        chk("in_ready_drop", {31'd0, ir[0]}, 32'd0);
        chk("busy_mac", {31'd0, bz[0]}, 32'd1);
        lat = 1;
        while (!ov[0] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd10);
        fill_exp(9, 32'd9);
        collect(9, 0);

        // Saturation with five-cycle backpressure on every output.
        send_frame(0, 32'h7FFF_FFFF);
        fill_exp(9, 32'h7FFF_FFFF);
        collect(9, 5);

        // Reset on the 4th MAC cycle, then reload pixels only.
        send_frame(0, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid",  {31'd0, ov[0]}, 32'd0);
        chk("midrst_in_ready",   {31'd0, ir[0]}, 32'd1);
        chk("midrst_busy",       {31'd0, bz[0]}, 32'd0);
        chk("midrst_coef_ready", {31'd0, cr[0]}, 32'd1);
        reset = 1'b0;
        send_frame(0, 32'd1);
        fill_exp(9, 32'd9);
        collect(9, 0);

        // Centre tap on ascending pixels picks buffer[(2*orow+1)*7 + 2*ocol+1].
        load_coef(1, 32'd0);
        send_frame(1, 32'd0);
        exp_q = '{32'd8, 32'd10, 32'd12, 32'd22, 32'd24, 32'd26, 32'd36, 32'd38, 32'd40};
        collect(9, 0);

        // PAD=1: corners 4, edges 6, interior 9.
        sel = 1;
        load_coef(0, 32'd0);
        send_frame(0, 32'd1);
        exp_q = '{32'd4, 32'd6, 32'd6, 32'd4,
                  32'd6, 32'd9, 32'd9, 32'd6,
                  32'd6, 32'd9, 32'd9, 32'd6,
                  32'd4, 32'd6, 32'd6, 32'd4};
        collect(16, 0);

        // RELU: bias -100 with zero input clamps to 0; 9*20-100 = 80 passes through.
        sel = 2;
        load_coef(0, 32'hFFFF_FF9C);
        send_frame(0, 32'd0);
        fill_exp(9, 32'd0);
        collect(9, 0);
        send_frame(0, 32'd20);
        fill_exp(9, 32'd80);
        collect(9, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_filter_stream.md
Name: conv_filter_stream

Overview:
- Sequential, parametrised successor to the combinational conv filter array.
- Accepts one square input feature map as a valid/ready word stream and buffers it.
- Computes every strided, zero-padded 2-D convolution output with a single time-multiplexed signed MAC, then streams the outputs in row-major order.
- Sits between the feature-map loader and the next layer; filter and bias are loaded once and kept across frames.

Parameters:
- DATA_W, 32, signed two's-complement width of input, filter, bias and output words.
- INPUT_SIZE, 7, input map edge length (map is INPUT_SIZE x INPUT_SIZE).
- FILTER_SIZE, 3, filter edge length.
- STRIDE, 2, step between output positions (both axes), >=1.
- PAD, 0, zero-padding rings around the input map, 0..FILTER_SIZE-1.
- RELU, 0, 1 = clamp negative results to 0 before output.
- Derived: OUT_SIZE = (INPUT_SIZE+2*PAD-FILTER_SIZE)/STRIDE+1; ACC_W = 2*DATA_W+clog2(FILTER_SIZE^2+1).

Ports:
- clk, input, 1, single clock, all logic rising-edge.
- reset, input, 1, synchronous, active-high reset.
- coef_valid, input, 1, coefficient word present.
- coef_ready, output, 1, block accepts coefficient words.
- coef_data, input, DATA_W, FILTER_SIZE^2 filter taps (row-major) followed by 1 bias word.
- in_valid, input, 1, input pixel present.
- in_ready, output, 1, block accepts input pixel.
- in_data, input, DATA_W, input pixel, row-major.
- out_valid, output, 1, output word present.
- out_ready, input, 1, downstream accepts output.
- out_data, output, DATA_W, convolution result.
- out_last, output, 1, high with the final output (index OUT_SIZE^2-1) of a frame.
- busy, output, 1, high in MAC or OUT state.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=LOAD, all counters 0, coef_ready=1, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0. Filter/bias storage is not cleared.
- A transfer occurs on any rising edge where valid&&ready.
- FSM LOAD:
  - in_ready=1. Each accepted pixel is written to buffer[pix_cnt]; pix_cnt increments.
  - coef_ready=1 only while pix_cnt==0. Coefficient words fill taps 0..K*K-1, then bias; coef_cnt wraps to 0 after bias.
  - If a coefficient and a pixel are both valid at pix_cnt==0, both are accepted in the same cycle.
  - When pixel INPUT_SIZE^2-1 is accepted: go to MAC, pix_cnt<=0, in_ready drops the next cycle.
  - If coefficient loading is incomplete, MAC uses whatever taps are stored; reloading mid-frame is not possible.
- FSM MAC:
  - Output position (orow,ocol); acc starts at sign-extended bias.
  - Exactly FILTER_SIZE^2 cycles, one tap per cycle (tr,tc row-major).
  - Tap address: r=orow*STRIDE+tr-PAD, c=ocol*STRIDE+tc-PAD. If r or c falls outside 0..INPUT_SIZE-1, the pixel is 0.
  - acc += pixel*tap, full-precision signed, ACC_W bits, no intermediate overflow.
  - After the last tap: go to OUT.
- FSM OUT:
  - out_data = acc saturated to the signed DATA_W range; if RELU, negative results become 0.
  - out_valid=1; out_data/out_last are held stable until out_ready.
  - On handshake: if last position, go to LOAD with out_valid=0 next cycle; else advance ocol (wrapping to the next orow) and go to MAC.
- Latency: first out_valid is FILTER_SIZE^2+1 cycles after the last pixel is accepted. Throughput is 1 output per FILTER_SIZE^2+1 cycles with out_ready held high.
- Reset asserted in any state: return to reset values next cycle; the partial frame is discarded; coefficients are retained.

Test Plan:
- Defaults: load all-ones filter with bias 0, then 49 pixels of 1 -> 9 outputs, each 9; out_last only on the 9th; first out_valid 10 cycles after the last pixel.
- Defaults: pixels 0..48 ascending, filter with centre tap 1 and others 0, bias 0 -> outputs 8,10,12,22,24,26,36,38,40.
- PAD=1, all-ones input and filter, bias 0 -> 16 outputs (4x4); corners 4, edges 6, interior 9.
- Defaults: all pixels 0x7FFFFFFF, all-ones filter -> every output 0x7FFFFFFF (saturated). RELU=1 with bias -100 and zero input -> outputs 0.
- Backpressure: hold out_ready low 5 cycles per output -> out_data stable while stalled, no outputs lost or duplicated, in_ready stays 0 until out_last handshakes.
- Reset asserted on the 4th MAC cycle -> next cycle in LOAD with out_valid=0. Reload 49 ones without coefficients -> outputs 9 (coefficients retained).
